// File: rtl/uart_rx_ip.sv
// UART 8N1 receiver for the SoC local bus: synchroniser, bit-timing FSM, RX FIFO
// and the RXDATA / STATUS / DIV register block.
module uart_rx_ip #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_uart_rx,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic [3:0]  wstrb,
  output logic        wready,
  input  logic [31:0] raddr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        o_rx_irq
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);
  localparam logic [15:0] DIV_MIN = 16'd4;

  localparam logic [3:0] OFF_RXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  // Bus handshake: ren/wen are single-cycle strobes that never overlap; every
  // ren is answered by exactly one rvalid pulse the next cycle, every wen by
  // one wready pulse the next cycle. There is no back-pressure on either side.

  logic [3:0] roff;
  logic [3:0] woff;
  assign roff = raddr[3:0];
  assign woff = waddr[3:0];

  logic unused_bits;
  assign unused_bits = ^{waddr[31:4], raddr[31:4], wdata[31:16], wstrb[3:2]};

  // ---------------------------------------------------------------------------
  // Line synchroniser and start-edge detect
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic rx_d;
  logic start_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      sync2 <= sync1;
      rx_d  <= sync2;
    end
  end

  assign start_edge = rx_d & ~sync2;

  // ---------------------------------------------------------------------------
  // Bit-timing FSM
  // ---------------------------------------------------------------------------
  logic [15:0] div_reg;
  rx_state_t   rx_state;
  rx_state_t   rx_state_next;
  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic [15:0] div_q;
  logic [15:0] div_q_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        push_req;
  logic        frame_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= ST_IDLE;
      cnt      <= 16'd0;
      div_q    <= DIV_RST;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
    end else begin
      rx_state <= rx_state_next;
      cnt      <= cnt_next;
      div_q    <= div_q_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    cnt_next      = cnt;
    div_q_next    = div_q;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    push_req      = 1'b0;
    frame_evt     = 1'b0;

    unique case (rx_state)
      ST_IDLE: begin
        // The divisor is frozen per frame so a DIV write mid-frame is harmless.
        if (start_edge) begin
          div_q_next    = div_reg;
          cnt_next      = div_reg >> 1;
          rx_state_next = ST_START;
        end
      end

      ST_START: begin
        if (cnt == 16'd0) begin
          if (!sync2) begin
            cnt_next      = div_q - 16'd1;
            bit_idx_next  = 3'd0;
            rx_state_next = ST_DATA;
          end else begin
            rx_state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end

      ST_DATA: begin
        if (cnt == 16'd0) begin
          shift_next = {sync2, shift[7:1]};
          cnt_next   = div_q - 16'd1;
          if (bit_idx == 3'd7) begin
            rx_state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end

      ST_STOP: begin
        // Returning to IDLE at the stop midpoint lets a back-to-back start be seen.
        if (cnt == 16'd0) begin
          rx_state_next = ST_IDLE;
          if (sync2) begin
            push_req = 1'b1;
          end else begin
            frame_evt = 1'b1;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end

      default: begin
        rx_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        ovr_evt;
  logic [7:0]  head;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign pop     = ren && (roff == OFF_RXDATA) && !empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push    = push_req && (!full || pop);
  assign ovr_evt = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= shift;
    end
  end

  assign o_rx_irq = ~empty;

  // ---------------------------------------------------------------------------
  // Sticky flags and DIV register
  // ---------------------------------------------------------------------------
  logic        overrun;
  logic        frame_err;
  logic        clr_ovr;
  logic        clr_ferr;
  logic        wr_div;
  logic [15:0] div_wr_val;
  logic [15:0] div_wr_clamped;

  assign clr_ovr  = wen && (woff == OFF_STATUS) && wstrb[0] && wdata[2];
  assign clr_ferr = wen && (woff == OFF_STATUS) && wstrb[0] && wdata[3];
  assign wr_div   = wen && (woff == OFF_DIV);

  always_comb begin
    div_wr_val = div_reg;
    if (wstrb[0]) begin
      div_wr_val[7:0] = wdata[7:0];
    end
    if (wstrb[1]) begin
      div_wr_val[15:8] = wdata[15:8];
    end
  end

  assign div_wr_clamped = (div_wr_val < DIV_MIN) ? DIV_MIN : div_wr_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      div_reg   <= DIV_RST;
    end else begin
      // An event in the same cycle as a W1C wins.
      overrun   <= (overrun & ~clr_ovr) | ovr_evt;
      frame_err <= (frame_err & ~clr_ferr) | frame_evt;
      if (wr_div) begin
        div_reg <= div_wr_clamped;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and bus response registers
  // ---------------------------------------------------------------------------
  logic [2:0]  status_cnt;
  logic [31:0] rd_mux;

  assign status_cnt = 3'(count);

  always_comb begin
    rd_mux = 32'd0;
    case (roff)
      OFF_RXDATA: rd_mux = empty ? 32'd0 : {23'd0, 1'b1, head};
      OFF_STATUS: rd_mux = {25'd0, status_cnt, frame_err, overrun, full, ~empty};
      OFF_DIV:    rd_mux = {16'd0, div_reg};
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= 32'd0;
      rvalid <= 1'b0;
      wready <= 1'b0;
    end else begin
      rvalid <= ren;
      wready <= wen;
      if (ren) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ip.sv
// Bench for uart_rx_ip: serial frames and bus traffic driven from tasks, read
// responses checked by a monitor against expectations from a byte-queue model.
module tb_uart_rx_ip;

  localparam int DEPTH = 4;
  localparam logic [15:0] DIV_RST = 16'd234;

  logic        clk;
  logic        rst;
  logic        i_uart_rx;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        wen;
  logic [3:0]  wstrb;
  logic        wready;
  logic [31:0] raddr;
  logic        ren;
  logic [31:0] rdata;
  logic        rvalid;
  logic        o_rx_irq;

  uart_rx_ip #(
    .CLKS_PER_BIT(234),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_uart_rx(i_uart_rx),
    .waddr    (waddr),
    .wdata    (wdata),
    .wen      (wen),
    .wstrb    (wstrb),
    .wready   (wready),
    .raddr    (raddr),
    .ren      (ren),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .o_rx_irq (o_rx_irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_issued = 0;
  int wready_seen = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  // ---------------- reference model ----------------
  logic [7:0]  mdl_fifo[$];
  bit          mdl_ovr;
  bit          mdl_ferr;
  logic [15:0] mdl_div;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = mdl_fifo.size();
    return {25'd0, 3'(n), mdl_ferr, mdl_ovr, (n == DEPTH), (n != 0)};
  endfunction

  task automatic model_reset();
    mdl_fifo.delete();
    mdl_ovr  = 1'b0;
    mdl_ferr = 1'b0;
    mdl_div  = DIV_RST;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data);
    data = 32'd0;
    case (addr[3:0])
      4'h0: if (mdl_fifo.size() != 0) data = {23'd0, 1'b1, mdl_fifo.pop_front()};
      4'h4: data = model_status();
      4'h8: data = {16'd0, mdl_div};
      default: data = 32'd0;
    endcase
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [15:0] nd;
    if (addr[3:0] == 4'h4 && strb[0]) begin
      if (data[2]) mdl_ovr = 1'b0;
      if (data[3]) mdl_ferr = 1'b0;
    end
    if (addr[3:0] == 4'h8) begin
      nd = mdl_div;
      if (strb[0]) nd[7:0] = data[7:0];
      if (strb[1]) nd[15:8] = data[15:8];
      mdl_div = (nd < 16'd4) ? 16'd4 : nd;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (wready) wready_seen++;
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h with no read outstanding", rdata);
      end else begin
        check(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [31:0] addr, input string name);
    logic [31:0] e;
    model_read(addr, e);
    exp_q.push_back(e);
    name_q.push_back(name);
    raddr = addr;
    ren   = 1'b1;
    @(posedge clk);
    #1;
    ren = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input string name);
    @(posedge clk);
    #1;
    issue_read(addr, name);
  endtask

  task automatic read_burst(input int n, input string name);
    logic [31:0] e;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      model_read(32'h0, e);
      exp_q.push_back(e);
      name_q.push_back(name);
      raddr = 32'h0;
      ren   = 1'b1;
      @(posedge clk);
      #1;
    end
    ren = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    model_write(addr, data, strb);
    @(posedge clk);
    #1;
    waddr = addr;
    wdata = data;
    wstrb = strb;
    wen   = 1'b1;
    wr_issued++;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_uart_rx = bits[i];
      repeat (mdl_div) @(posedge clk);
      #1;
    end
    if (stop_bit) begin
      if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back(b);
      else mdl_ovr = 1'b1;
    end else begin
      mdl_ferr = 1'b1;
    end
    i_uart_rx = 1'b1;
    if (!stop_bit) begin
      repeat (mdl_div) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_irq(input string name);
    @(negedge clk);
    check(name, {31'd0, o_rx_irq}, {31'd0, (mdl_fifo.size() != 0)});
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    total_cnt++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst       = 1'b1;
    i_uart_rx = 1'b1;
    waddr     = 32'd0;
    wdata     = 32'd0;
    wen       = 1'b0;
    wstrb     = 4'd0;
    raddr     = 32'd0;
    ren       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_irq", {31'd0, o_rx_irq}, 32'd0);
    @(posedge clk);
    #1;
    bus_read(32'h8, "rst_div");
    bus_read(32'h4, "rst_status");
    bus_read(32'hC, "undecoded_read");

    // Single frame
    bus_write(32'h8, 32'd16, 4'b0011);
    send_frame(8'hA5, 1'b1);
    cyc(3);
    check_irq("irq_after_a5");
    bus_read(32'h4, "status_a5");
    bus_read(32'h0, "rxdata_a5");
    bus_read(32'h4, "status_after_pop");
    bus_read(32'h0, "rxdata_empty");
    check_irq("irq_after_pop");

    // Overrun with five back-to-back frames
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    cyc(3);
    bus_read(32'h4, "status_overrun");
    read_burst(4, "rxdata_burst");
    bus_read(32'h0, "rxdata_after_drain");
    bus_read(32'h4, "status_ovr_sticky");
    bus_write(32'h4, 32'h4, 4'b0001);
    bus_read(32'h4, "status_ovr_cleared");

    // Push into a full FIFO on the same cycle as a pop
    for (int k = 0; k < 4; k++) send_frame(8'(8'h11 + k), 1'b1);
    fork
      send_frame(8'h15, 1'b1);
      begin
        repeat (3 + mdl_div / 2 + 9 * mdl_div) @(posedge clk);
        #1;
        issue_read(32'h0, "rxdata_pop_at_push");
      end
    join
    cyc(3);
    bus_read(32'h4, "status_full_no_ovr");
    read_burst(4, "rxdata_wrap");
    bus_read(32'h0, "rxdata_wrap_empty");

    // Framing error and W1C
    send_frame(8'h3C, 1'b0);
    cyc(3);
    bus_read(32'h4, "status_ferr");
    bus_write(32'h4, 32'h8, 4'b0000);
    bus_read(32'h4, "status_ferr_nostrb");
    bus_write(32'h4, 32'h8, 4'b0001);
    bus_read(32'h4, "status_ferr_cleared");

    // Short glitch, then a valid frame
    i_uart_rx = 1'b0;
    cyc(4);
    i_uart_rx = 1'b1;
    cyc(40);
    bus_read(32'h4, "status_glitch");
    send_frame(8'h7E, 1'b1);
    cyc(3);
    bus_read(32'h0, "rxdata_7e");

    // DIV byte enables and clamp
    bus_write(32'h8, 32'h0000_0002, 4'b0001);
    bus_read(32'h8, "div_clamp");
    bus_write(32'h8, 32'h0000_0312, 4'b0010);
    bus_read(32'h8, "div_hi_byte");
    bus_write(32'h8, 32'h1234_0014, 4'b0001);
    bus_read(32'h8, "div_lo_byte");
    bus_write(32'hC, 32'hFFFF_FFFF, 4'b1111);
    bus_read(32'h8, "div_after_undecoded_write");

    // Reset mid-frame with stored state
    bus_write(32'h8, 32'd16, 4'b0011);
    send_frame(8'h99, 1'b1);
    send_frame(8'h3C, 1'b0);
    cyc(3);
    bus_read(32'h4, "status_before_rst");
    begin
      logic [7:0] b55;
      b55 = 8'h55;
      i_uart_rx = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        i_uart_rx = b55[i];
        repeat (16) @(posedge clk);
        #1;
      end
      i_uart_rx = b55[3];
      repeat (8) @(posedge clk);
      #1;
    end
    rst       = 1'b1;
    i_uart_rx = 1'b1;
    model_reset();
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check_irq("irq_after_rst");
    bus_read(32'h4, "status_after_rst");
    bus_read(32'h8, "div_after_rst");
    bus_read(32'h0, "rxdata_after_rst");
    bus_write(32'h8, 32'd16, 4'b0011);
    send_frame(8'hC3, 1'b1);
    cyc(3);
    bus_read(32'h0, "rxdata_c3");

    // Randomized traffic
    for (int it = 0; it < 16; it++) begin
      int          d;
      int          nf;
      int          nr;
      logic [7:0]  b;
      bit          sb;
      d = $urandom_range(12, 32);
      bus_write(32'h8, 32'(d), 4'b0011);
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        b  = 8'($urandom_range(0, 255));
        sb = ($urandom_range(0, 7) != 0);
        send_frame(b, sb);
      end
      cyc(3);
      check_irq("irq_rand");
      bus_read(32'h4, "status_rand");
      nr = $urandom_range(0, 3);
      for (int r = 0; r < nr; r++) bus_read(32'h0, "rxdata_rand");
      if ($urandom_range(0, 3) == 0) bus_write(32'h4, 32'($urandom_range(0, 15)), 4'b0001);
    end
    bus_read(32'h4, "status_final");

    cyc(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("wready_count", 32'(wready_seen), 32'(wr_issued));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_ip.md
# uart_rx_ip

UART receiver peripheral on the SoC local bus, the receive counterpart to the existing UART transmitter. It deserialises 8N1 frames from the `i_uart_rx` pin, stores received bytes in a small FIFO and exposes data, status and baud divisor registers to FemtoRV32. It decodes on the local bus next to the GPIO and UART TX blocks and gets its own `device_select` slot.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 234: reset value of DIV (clk cycles per bit; 27 MHz / 115200).
- `FIFO_DEPTH`, default 4: RX FIFO entries; power of 2, minimum 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: synchronous active-high reset.
- `i_uart_rx` input 1: serial line, idle high, asynchronous to `clk`.
- `waddr` input 32: write address; only `[3:0]` decoded.
- `wdata` input 32: write data.
- `wen` input 1: write strobe, one cycle.
- `wstrb` input 4: byte enables.
- `wready` output 1: write acknowledge.
- `raddr` input 32: read address; only `[3:0]` decoded.
- `ren` input 1: read strobe, one cycle.
- `rdata` output 32: read data.
- `rvalid` output 1: read data valid.
- `o_rx_irq` output 1: high while the FIFO is not empty.

## Operation
Register map (byte offsets). Undecoded offsets read 0 and ignore writes.
- 0x0 RXDATA, RO: `[7:0]` is the FIFO head byte and `[8]` is 1 if the FIFO was non-empty. A read pops one entry. A read when empty returns 0 and pops nothing.
- 0x4 STATUS:
  - `[0]` not_empty, `[1]` full, `[2]` overrun (sticky), `[3]` frame_err (sticky), `[6:4]` FIFO count.
  - Writing 1 to `[2]` or `[3]` with `wstrb[0]` set clears that bit. All other bits are RO.
- 0x8 DIV, RW: `[15:0]` clocks per bit. Byte writes follow `wstrb[1:0]`. A resulting value below 4 is stored as 4.

Input path:
- `i_uart_rx` passes through a 2-flop synchroniser, reset value 1, plus a 1-flop delayed copy for edge detect.
- A start is a synchronised 1→0 edge.

FSM states: IDLE, START, DATA, STOP.
- IDLE: on a start edge, latch DIV into `div_q`, load the counter with `div_q>>1`, go to START.
- START: when the counter reaches 0, sample the line. If 0, reload `div_q-1`, clear the bit index and go to DATA. If 1 (glitch), go to IDLE and record nothing.
- DATA: each time the counter reaches 0, sample the line into the shift register LSB-first and reload `div_q-1`. After bit index 7, go to STOP.
- STOP: when the counter reaches 0, sample the line, then go to IDLE.
  - Sample 1: push the byte.
  - Sample 0: discard the byte and set frame_err.
- A DIV write during a frame takes effect at the next start edge.

FIFO:
- Circular buffer with read and write pointers of `log2(FIFO_DEPTH)+1` bits; full/empty are derived from the pointers.
- Push when full: the byte is dropped and overrun is set.
- Push and pop in the same cycle: both happen and count is unchanged. A push into a full FIFO with a same-cycle pop is accepted and does not set overrun.
- Pointers wrap modulo `2*FIFO_DEPTH`.

Status write vs. event:
- A W1C in the same cycle as a new overrun or frame event leaves the flag set (the event wins).

Reset:
- Takes effect at any point, including mid-frame.
- Returns the FSM to IDLE, empties the FIFO, clears the flags and sets DIV to `CLKS_PER_BIT`. The synchroniser flops reset to 1.

## Timing
- Reset values: `wready`=0, `rvalid`=0, `rdata`=0, `o_rx_irq`=0.
- Read: `ren` in cycle N gives `rdata`/`rvalid` registered in cycle N+1, with `rvalid` high for exactly one cycle. The pop occurs at the N edge. `rdata` holds its value until the next read.
- Write: `wen` in cycle N updates the register at the N edge. `wready` pulses for one cycle at N+1.
- The bus issues no overlapping `ren`/`wen`. A `ren` in every cycle pops once per cycle.
- Line to sample: synchroniser latency is 2 cycles. The start is sampled `DIV/2` cycles after the edge is detected, then each data bit at `DIV` cycle intervals.
- Push to FIFO occurs on the cycle the stop bit is sampled. `o_rx_irq` rises the following cycle.
- Back-to-back frames are supported: after STOP, IDLE is entered at the stop-bit midpoint and a new start edge is detected immediately.

## Test plan
- Reset, then read 0x8 → 234; read 0x4 → 0; `o_rx_irq`=0.
- DIV=16, send frame 0xA5 → `o_rx_irq`=1, STATUS=0x11. Read RXDATA → 0x1A5. Next STATUS read → 0x00.
- DIV=16, send 5 back-to-back frames 0x01..0x05 with no reads → count 4, full=1, overrun=1. Four RXDATA reads → 0x101..0x104. Fifth read → 0.
- Send 0x3C with stop bit driven 0 → FIFO empty, STATUS[3]=1. Write 0x8 to 0x4 → STATUS=0.
- Send a 0-pulse of 4 cycles with DIV=16 → no byte and no flags. Then send a valid frame 0x7E → 0x17E received.
- Assert `rst` at the midpoint of bit 3 of frame 0x55 → all state cleared. Next frame 0xC3 → 0x1C3 received correctly.
